pipe_elastic_reg: RTL
=====================

Name: pipe_elastic_reg

Overview:
Parametrised elastic pipeline register chain for the CPU datapath. It succeeds the plain flop library and generalises the enable/reset flop into a DEPTH-stage, WIDTH-bit register chain with per-stage valid bits, a valid/ready handshake, bubble collapsing and a synchronous flush. It sits between CPU pipeline stages (e.g. IF/ID, ID/EX), so hazard logic drives stall through ready and branch logic drives flush.

Parameters:
WIDTH, 32, payload width in bits; legal range 1 or more.
DEPTH, 1, number of register stages; legal range 1..8.

Ports:
clk  input  1  clock; all state updates on the rising edge.
r_n  input  1  asynchronous active-low reset.
flush  input  1  synchronous flush; drops all held entries.
in_valid  input  1  upstream has a valid payload.
in_ready  output  1  stage 0 can accept this cycle.
in_data  input  WIDTH  upstream payload.
out_valid  output  1  last stage holds a valid payload.
out_ready  input  1  downstream accepts this cycle.
out_data  output  WIDTH  last-stage payload.

Behaviour:
- Reset: clk single clock domain; r_n asynchronous active-low. While r_n=0, every valid bit and every data register is 0, so out_valid=0 and out_data=0. in_ready follows its equation (1 when flush=0). Reset release is sampled on the next clk edge.
- Per stage i (0..DEPTH-1): registers v[i] and d[i].
- Stage advance: adv[DEPTH-1] = out_ready | ~v[DEPTH-1]; for i<DEPTH-1, adv[i] = adv[i+1] | ~v[i]. This is combinational and ripples from out_ready to in_ready, which is intended. Bubbles collapse: an empty stage always accepts.
- Load: stage 0 loads in_data/in_valid when adv[0]. Stage i>0 loads from stage i-1 when adv[i]. The loaded valid equals the source valid, so empty slots propagate as bubbles. When adv[i]=0, stage i holds.
- in_ready = adv[0] & ~flush. The input transfer is in_valid & in_ready.
- out_valid = v[DEPTH-1]; out_data = d[DEPTH-1]. out_data must stay stable while out_valid=1 and out_ready=0.
- Latency: DEPTH cycles from input transfer to out_valid with no backpressure. Throughput is 1 per cycle at steady state.
- Flush: has priority over load. On a clk edge with flush=1, all v[i] are cleared to 0. Data registers may keep stale values; they are don't-care when invalid. Any input presented in a flush cycle is dropped, since in_ready=0. An entry at the output with out_ready=1 in the flush cycle counts as consumed, because the downstream sampled it.
- Simultaneous full chain and out_ready=1: every stage shifts, stage 0 accepts new input, and nothing is lost.
- Reset asserted mid-operation: all state clears immediately, asynchronously; held entries are lost.
- No entry is ever duplicated or reordered.

Optional Feature:
Macro PIPE_OCC_CNT_EN.
- Defined: adds output port occupancy, width clog2(DEPTH+1), equal to the number of set v[i]. It is registered and updated on the same edge as v, resets to 0, and reads 0 after a flush.
- Undefined: the port and counter logic are absent; all other behaviour is identical.

Decomposition:
- Package pipe_pkg holds:
  - the DEPTH_MAX=8 constant;
  - a clog2 constant function;
  - a default WIDTH constant.
- Sub-module pipe_slot: one stage, i.e. a valid flop plus a WIDTH data flop with load enable, synchronous clear (valid only) and asynchronous active-low reset. It is instantiated DEPTH times in a generate loop.

Test Plan:
- Reset: r_n=0 mid-stream with DEPTH=3 and all stages full -> out_valid=0 and out_data=0 immediately, without a clk edge; in_ready=1 after release.
- Streaming: DEPTH=3, out_ready=1, in_data=1,2,3,4 on consecutive cycles -> out_valid rises 3 cycles after the first transfer; out_data=1,2,3,4 back-to-back.
- Backpressure: DEPTH=2, fill with 0xA and 0xB, out_ready=0 -> in_ready=0, out_data holds 0xA. Raise out_ready for 1 cycle -> 0xA consumed, in_ready=1 in the same cycle.
- Bubble collapse: DEPTH=4, single entry 0x5, out_ready=0 -> 0x5 reaches the last stage after 4 cycles; entries 0x6 and 0x7 then fill behind it with no gaps.
- Flush: DEPTH=3 full, flush=1 with in_valid=1 and in_data=0x9 -> next cycle out_valid=0, 0x9 never appears at out_data, occupancy=0 (with PIPE_OCC_CNT_EN).
- Occupancy (PIPE_OCC_CNT_EN, DEPTH=4): 3 transfers with out_ready=0 -> occupancy=3. Then 1 out transfer with no input -> occupancy=2.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the elastic pipeline register chain.
// Imported by pipe_slot and pipe_elastic_reg.
package pipe_pkg;

    localparam int DEPTH_MAX     = 8;
    localparam int WIDTH_DEFAULT = 32;

    // Ceiling log2, floored at 1 so that a counter port is never zero-width.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One elastic pipeline stage: a valid flop and a payload flop sharing a load enable.
// Clear drops only the valid bit; the payload is don't-care while invalid.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             r_n,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;

    // Clear outranks load, so a flushed stage always comes out empty.
    always_ff @(posedge clk or negedge r_n) begin
        if (!r_n) begin
            valid_q <= 1'b0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= valid_i;
        end
    end

    always_ff @(posedge clk or negedge r_n) begin
        if (!r_n) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_elastic_reg.sv
// DEPTH-stage elastic register chain with valid/ready handshake, bubble collapsing and flush.
// Define PIPE_OCC_CNT_EN to add the registered occupancy output.
module pipe_elastic_reg
    import pipe_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             r_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef PIPE_OCC_CNT_EN
    ,
    output logic [clog2(DEPTH+1)-1:0] occupancy
`endif
);

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] adv;
    logic [WIDTH-1:0] d [DEPTH];
`ifdef PIPE_OCC_CNT_EN
    logic [DEPTH-1:0] nextValid;
`endif

    // A stage advances when its successor advances or it is empty, so bubbles collapse.
    always_comb begin
        logic carry;
        carry          = out_ready | ~v[DEPTH-1];
        adv[DEPTH-1]   = carry;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            carry  = carry | ~v[i];
            adv[i] = carry;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             srcValid;
        logic [WIDTH-1:0] srcData;

        if (i == 0) begin : g_head
            assign srcValid = in_valid;
            assign srcData  = in_data;
        end else begin : g_body
            assign srcValid = v[i-1];
            assign srcData  = d[i-1];
        end

`ifdef PIPE_OCC_CNT_EN
        assign nextValid[i] = adv[i] ? srcValid : v[i];
`endif

        pipe_slot #(
            .WIDTH(WIDTH)
        ) u_slot (
            .clk     (clk),
            .r_n     (r_n),
            .clear_i (flush),
            .load_i  (adv[i]),
            .valid_i (srcValid),
            .data_i  (srcData),
            .valid_o (v[i]),
            .data_o  (d[i])
        );
    end

    assign in_ready  = adv[0] & ~flush;
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];

`ifdef PIPE_OCC_CNT_EN
    localparam int OCC_W = clog2(DEPTH + 1);

    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;

    // Count the valid bits the chain will hold after this edge, so the counter tracks v exactly.
    always_comb begin
        occ_d = '0;
        if (!flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                occ_d = occ_d + OCC_W'(nextValid[i]);
            end
        end
    end

    always_ff @(posedge clk or negedge r_n) begin
        if (!r_n) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy = occ_q;
`endif

endmodule
